// File: rtl/pc_fetch_if.sv
// pc_fetch_if: fetch-unit bus bundling the memory req/ack port and the decode/execute retire port.
interface pc_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              jmp;
  logic              incr;
  logic [ADDR_W-1:0] jmp_target;
  logic              halt;
  logic              halted;
  logic [15:0]       retired;
  modport master (
    output mem_addr, mem_req, instr, instr_valid, halted, retired,
    input  mem_ack, mem_rdata, instr_ready, jmp, incr, jmp_target, halt
  );
  modport slave (
    input  mem_addr, mem_req, instr, instr_valid, halted, retired,
    output mem_ack, mem_rdata, instr_ready, jmp, incr, jmp_target, halt
  );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and req/ack instruction fetch sequencer with retire count and sticky halt.
module pc_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         rst,
  pc_fetch_if.master  bus
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} stateT;
  stateT             state, stateNext;
  logic [ADDR_W-1:0] pc, pcNext;
  logic [DATA_W-1:0] instrQ, instrNext;
  logic [15:0]       retiredQ, retiredNext;
  logic              memReqQ, instrValidQ, haltedQ;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instrQ      <= '0;
      retiredQ    <= '0;
      memReqQ     <= 1'b0;
      instrValidQ <= 1'b0;
      haltedQ     <= 1'b0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      instrQ      <= instrNext;
      retiredQ    <= retiredNext;
      memReqQ     <= stateNext == FETCH;
      instrValidQ <= stateNext == HOLD;
      haltedQ     <= stateNext == HALT;
    end
  end
  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    instrNext   = instrQ;
    retiredNext = retiredQ;
    unique case (state)
      IDLE:  stateNext = FETCH;
      FETCH: if (bus.mem_ack) begin
        instrNext = bus.mem_rdata;
        stateNext = HOLD;
      end
      HOLD:  if (bus.instr_ready) begin
        // jmp has priority; neither bit set re-fetches the current pc
        pcNext      = bus.jmp ? bus.jmp_target : bus.incr ? pc + ADDR_W'(1) : pc;
        retiredNext = retiredQ + 16'd1;
        stateNext   = bus.halt ? HALT : FETCH;
      end
      default: stateNext = HALT;
    endcase
  end
  assign bus.mem_addr    = pc;
  assign bus.mem_req     = memReqQ;
  assign bus.instr       = instrQ;
  assign bus.instr_valid = instrValidQ;
  assign bus.halted      = haltedQ;
  assign bus.retired     = retiredQ;
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed table-driven checks of pc_fetch against a latency-programmable memory responder.
module tb_pc_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pc_fetch_if bus ();
  pc_fetch dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int fails = 0;
  int ackLat = 0;
  bit ackForce = 1'b0;
  int waitCnt = 0;
  typedef struct {
    logic        jmp;
    logic        incr;
    logic [15:0] target;
    int          lat;
    logic [15:0] expAddr;
  } vecT;
  vecT vecs[11];
  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // memory model: acks after ackLat wait cycles; ackForce drives ack while no request is pending
  always @(negedge clk) begin
    bus.mem_rdata = memWord(bus.mem_addr);
    if (bus.mem_req) begin
      bus.mem_ack = waitCnt >= ackLat;
      if (waitCnt < ackLat) waitCnt++;
    end else begin
      bus.mem_ack = ackForce;
      waitCnt = 0;
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.instr_valid && bus.mem_req) begin
        fails++;
        $display("FAIL req_valid_overlap: got both 1 expected exclusive at %0t", $time);
      end
    end
  end
  task automatic waitValid(input string name);
    int n = 0;
    while (!bus.instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, " wait_valid"}, {31'd0, bus.instr_valid}, 32'd1);
  endtask
  task automatic retire(input string name, input logic j, input logic i, input logic [15:0] t, input logic h);
    waitValid(name);
    bus.instr_ready = 1'b1;
    bus.jmp = j;
    bus.incr = i;
    bus.jmp_target = t;
    bus.halt = h;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.jmp = 1'b0;
    bus.incr = 1'b0;
    bus.jmp_target = 16'h0000;
    bus.halt = 1'b0;
  endtask
  initial begin
    int n;
    vecs[0]  = '{1'b0, 1'b1, 16'h0000, 3, 16'h0001};
    vecs[1]  = '{1'b0, 1'b1, 16'h0000, 3, 16'h0002};
    vecs[2]  = '{1'b0, 1'b1, 16'h0000, 3, 16'h0003};
    vecs[3]  = '{1'b1, 1'b0, 16'h0005, 0, 16'h0005};
    vecs[4]  = '{1'b1, 1'b0, 16'h0040, 1, 16'h0040};
    vecs[5]  = '{1'b1, 1'b0, 16'h0005, 2, 16'h0005};
    vecs[6]  = '{1'b1, 1'b1, 16'h0040, 0, 16'h0040};
    vecs[7]  = '{1'b0, 1'b0, 16'h1234, 1, 16'h0040};
    vecs[8]  = '{1'b1, 1'b0, 16'hFFFF, 0, 16'hFFFF};
    vecs[9]  = '{1'b0, 1'b1, 16'h0000, 2, 16'h0000};
    vecs[10] = '{1'b1, 1'b0, 16'h0010, 0, 16'h0010};
    bus.instr_ready = 1'b0;
    bus.jmp = 1'b0;
    bus.incr = 1'b0;
    bus.jmp_target = 16'h0000;
    bus.halt = 1'b0;
    ackForce = 1'b1;
    ackLat = 0;
    @(negedge clk);
    check("rst mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst mem_addr", {16'd0, bus.mem_addr}, 32'h0000);
    check("rst instr", {16'd0, bus.instr}, 32'h0000);
    check("rst instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst halted", {31'd0, bus.halted}, 32'd0);
    check("rst retired", {16'd0, bus.retired}, 32'd0);
    rst = 1'b0;
    #1 check("idle bubble mem_req", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
    check("first fetch mem_req", {31'd0, bus.mem_req}, 32'd1);
    check("first fetch addr", {16'd0, bus.mem_addr}, 32'h0000);
    check("first fetch valid", {31'd0, bus.instr_valid}, 32'd0);
    @(negedge clk);
    check("first hold valid", {31'd0, bus.instr_valid}, 32'd1);
    check("first hold mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("first hold instr", {16'd0, bus.instr}, {16'd0, memWord(16'h0000)});
    ackForce = 1'b0;
    repeat (2) @(negedge clk);
    check("hold stable instr", {16'd0, bus.instr}, {16'd0, memWord(16'h0000)});
    check("hold stable valid", {31'd0, bus.instr_valid}, 32'd1);
    check("hold no retire", {16'd0, bus.retired}, 32'd0);
    for (int k = 0; k < 11; k++) begin
      ackLat = vecs[k].lat;
      retire($sformatf("v%0d", k), vecs[k].jmp, vecs[k].incr, vecs[k].target, 1'b0);
      n = 0;
      while (bus.mem_req && n < 50) begin
        check($sformatf("v%0d mem_addr", k), {16'd0, bus.mem_addr}, {16'd0, vecs[k].expAddr});
        n++;
        @(negedge clk);
      end
      check($sformatf("v%0d req_cycles", k), n, vecs[k].lat + 1);
      check($sformatf("v%0d valid", k), {31'd0, bus.instr_valid}, 32'd1);
      check($sformatf("v%0d instr", k), {16'd0, bus.instr}, {16'd0, memWord(vecs[k].expAddr)});
      check($sformatf("v%0d retired", k), {16'd0, bus.retired}, k + 1);
    end
    retire("halt", 1'b0, 1'b1, 16'h0000, 1'b1);
    check("halt halted", {31'd0, bus.halted}, 32'd1);
    check("halt pc", {16'd0, bus.mem_addr}, 32'h0011);
    check("halt valid", {31'd0, bus.instr_valid}, 32'd0);
    check("halt retired", {16'd0, bus.retired}, 32'd12);
    ackForce = 1'b1;
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("halt c%0d mem_req", k), {31'd0, bus.mem_req}, 32'd0);
    end
    check("halt sticky", {31'd0, bus.halted}, 32'd1);
    check("halt no count", {16'd0, bus.retired}, 32'd12);
    check("halt pc held", {16'd0, bus.mem_addr}, 32'h0011);
    bus.instr_ready = 1'b0;
    ackForce = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ackLat = 0;
    #1 check("rst2 bubble", {31'd0, bus.mem_req}, 32'd0);
    retire("r2", 1'b1, 1'b0, 16'h0123, 1'b0);
    ackLat = 1000;
    check("r2 mem_req", {31'd0, bus.mem_req}, 32'd1);
    check("r2 addr", {16'd0, bus.mem_addr}, 32'h0123);
    check("r2 retired", {16'd0, bus.retired}, 32'd1);
    repeat (3) @(negedge clk);
    check("r2 wait req", {31'd0, bus.mem_req}, 32'd1);
    check("r2 wait addr", {16'd0, bus.mem_addr}, 32'h0123);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("async rst addr", {16'd0, bus.mem_addr}, 32'h0000);
    check("async rst retired", {16'd0, bus.retired}, 32'd0);
    check("async rst valid", {31'd0, bus.instr_valid}, 32'd0);
    check("async rst instr", {16'd0, bus.instr}, 32'h0000);
    @(negedge clk);
    rst = 1'b0;
    ackLat = 0;
    #1 check("rst3 bubble", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
    check("rst3 fetch req", {31'd0, bus.mem_req}, 32'd1);
    check("rst3 fetch addr", {16'd0, bus.mem_addr}, 32'h0000);
    @(negedge clk);
    check("rst3 valid", {31'd0, bus.instr_valid}, 32'd1);
    check("rst3 instr", {16'd0, bus.instr}, {16'd0, memWord(16'h0000)});
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
